// File: rtl/ball_pkg.sv
// Shared types and keycode constants for the ball motion datapath.
package ball_pkg;

  // Screen coordinate / motion word, 10-bit two's complement for motion
  typedef logic [9:0] coord_t;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } ball_state_t;

  // USB HID keycodes
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser for an asynchronous strobe followed by a history
// flop; emits a registered one-clock pulse on each synchronised rising edge.
module pulse_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic hist_reg;
  logic pulse_reg;

  // Synchronise, keep one cycle of history, register the rising-edge pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
      pulse_reg <= sync2_reg & ~hist_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position sequencer: WASD steering, wall bounce and a
// space-bar pause, advancing once per detected VGA frame boundary.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int STEP     = 1,
  parameter int SIZE     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       paused,
  output logic       frame_tick
);

  // Wall limits widened to 11 bits so position + SIZE never overflows
  localparam logic [10:0] X_LO_W = 11'(X_MIN + SIZE);
  localparam logic [10:0] X_HI_W = 11'(X_MAX);
  localparam logic [10:0] Y_LO_W = 11'(Y_MIN + SIZE);
  localparam logic [10:0] Y_HI_W = 11'(Y_MAX);
  localparam logic [10:0] SIZE_W = 11'(SIZE);
  localparam coord_t      STEP_POS = coord_t'(STEP);
  localparam coord_t      STEP_NEG = coord_t'(10'd0 - STEP_POS);

  ball_state_t state_reg, state_next;
  coord_t      ball_x_reg, ball_x_next;
  coord_t      ball_y_reg, ball_y_next;
  coord_t      motion_x_reg, motion_x_next;
  coord_t      motion_y_reg, motion_y_next;
  logic [7:0]  last_key_reg;
  logic        space_press;
  logic        x_forced, y_forced;

  pulse_sync u_frame_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .pulse    (frame_tick)
  );

  assign space_press = (keycode == KEY_SPACE) && (last_key_reg != KEY_SPACE);

  // Next state, motion and position; a tick uses the pre-toggle state
  always_comb begin
    state_next    = state_reg;
    motion_x_next = motion_x_reg;
    motion_y_next = motion_y_reg;
    ball_x_next   = ball_x_reg;
    ball_y_next   = ball_y_reg;
    x_forced      = 1'b0;
    y_forced      = 1'b0;

    if (space_press) begin
      state_next = (state_reg == RUN) ? PAUSED : RUN;
    end

    if (frame_tick && (state_reg == RUN)) begin
      if (({1'b0, ball_y_reg} + SIZE_W) >= Y_HI_W) begin
        motion_y_next = STEP_NEG;
        y_forced      = 1'b1;
      end else if ({1'b0, ball_y_reg} <= Y_LO_W) begin
        motion_y_next = STEP_POS;
        y_forced      = 1'b1;
      end

      if (({1'b0, ball_x_reg} + SIZE_W) >= X_HI_W) begin
        motion_x_next = STEP_NEG;
        x_forced      = 1'b1;
      end else if ({1'b0, ball_x_reg} <= X_LO_W) begin
        motion_x_next = STEP_POS;
        x_forced      = 1'b1;
      end

      // Keys only steer axes that no wall claimed this frame
      case (keycode)
        KEY_W: begin
          if (!y_forced) motion_y_next = STEP_NEG;
          if (!x_forced) motion_x_next = '0;
        end
        KEY_S: begin
          if (!y_forced) motion_y_next = STEP_POS;
          if (!x_forced) motion_x_next = '0;
        end
        KEY_A: begin
          if (!x_forced) motion_x_next = STEP_NEG;
          if (!y_forced) motion_y_next = '0;
        end
        KEY_D: begin
          if (!x_forced) motion_x_next = STEP_POS;
          if (!y_forced) motion_y_next = '0;
        end
        default: ;
      endcase

      ball_x_next = ball_x_reg + motion_x_next;
      ball_y_next = ball_y_reg + motion_y_next;
    end
  end

  // State, motion, position and key-history registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= RUN;
      ball_x_reg   <= coord_t'(X_CENTER);
      ball_y_reg   <= coord_t'(Y_CENTER);
      motion_x_reg <= '0;
      motion_y_reg <= '0;
      last_key_reg <= 8'h00;
    end else begin
      state_reg    <= state_next;
      ball_x_reg   <= ball_x_next;
      ball_y_reg   <= ball_y_next;
      motion_x_reg <= motion_x_next;
      motion_y_reg <= motion_y_next;
      last_key_reg <= keycode;
    end
  end

  assign BallX     = ball_x_reg;
  assign BallY     = ball_y_reg;
  assign Ball_size = 10'(SIZE);
  assign paused    = (state_reg == PAUSED);

endmodule
